// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder
//   Responder for the instruction-fetch request channel. Requests (address +
//   pre-translated TLB exception) are accepted with an addr_ok handshake. Each
//   request without an exception becomes a read of a 1-cycle synchronous
//   instruction RAM. Responses come back strictly in order, exactly LATENCY
//   cycles after acceptance. cancel drops every outstanding fetch.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req/req_addr/req_ex fetch request, word address, TLB exception (0 = none)
//   addr_ok             request accepted when req && addr_ok
//   cancel              flush all outstanding fetches
//   data_ok/rdata/resp_ex  single-cycle in-order response
//   mem_en/mem_addr     RAM read port (mem_addr is req_addr, combinational)
//   mem_rdata           RAM data, valid the cycle after mem_en

// One outstanding-fetch slot: latency countdown, exception code and data.
module inst_fetch_responder_entry #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        flush,
    input  logic        load,
    input  logic [1:0]  load_ex,
    input  logic        pop,
    input  logic        fill,
    input  logic [31:0] mem_rdata,
    output logic        rdy,
    output logic [1:0]  ex,
    output logic [31:0] data
);
    localparam int TW = $clog2(LATENCY + 1);

    logic          valid;
    logic          filled;
    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (flush) begin
            valid  <= 1'b0;
            filled <= 1'b0;
            timer  <= '0;
            ex     <= 2'b00;
            data   <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            filled <= 1'b0;
            ex     <= load_ex;
            timer  <= TW'(LATENCY - 1);
            data   <= '0;
        end else begin
            if (pop) begin
                valid  <= 1'b0;
                filled <= 1'b0;
            end
            if (valid && timer != '0)
                timer <= timer - 1'b1;
            // Excepting fetches never read the RAM; their data is forced to 0.
            if (fill && valid) begin
                filled <= 1'b1;
                data   <= (ex != 2'b00) ? 32'h0 : mem_rdata;
            end
        end
    end

    assign rdy = valid && filled && (timer == '0);
endmodule

module inst_fetch_responder #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_ex,
    output logic              addr_ok,
    input  logic              cancel,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic [1:0]        resp_ex,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic          accept, pop, flush;

    // Slot written last cycle; its RAM data lands this cycle.
    logic          fill_pend;
    logic [PW-1:0] fill_idx;

    logic [DEPTH-1:0]       ent_rdy;
    logic [DEPTH-1:0][1:0]  ent_ex;
    logic [DEPTH-1:0][31:0] ent_data;

    assign flush   = rst || cancel;
    // No bypass: a pop in the same cycle does not free a slot for acceptance.
    assign addr_ok = !flush && (count < CW'(DEPTH));
    assign accept  = req && addr_ok;
    assign mem_en  = accept && (req_ex == 2'b00);
    assign mem_addr = req_addr;

    assign data_ok = !flush && ent_rdy[rp];
    assign pop     = data_ok;
    assign rdata   = data_ok ? ent_data[rp] : 32'h0;
    assign resp_ex = data_ok ? ent_ex[rp]   : 2'b00;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        inst_fetch_responder_entry #(.LATENCY(LATENCY)) u_ent (
            .clk       (clk),
            .flush     (flush),
            .load      (accept && (wp == PW'(g))),
            .load_ex   (req_ex),
            .pop       (pop && (rp == PW'(g))),
            .fill      (fill_pend && (fill_idx == PW'(g))),
            .mem_rdata (mem_rdata),
            .rdy       (ent_rdy[g]),
            .ex        (ent_ex[g]),
            .data      (ent_data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            fill_pend <= 1'b0;  // RAM data for a cancelled fetch is dropped
            fill_idx  <= '0;
        end else begin
            if (accept) wp <= wp + 1'b1;
            if (pop)    rp <= rp + 1'b1;
            count     <= count + CW'(accept) - CW'(pop);
            fill_pend <= accept;
            fill_idx  <= wp;
        end
    end
endmodule

// File: tb/tb_inst_fetch_responder.sv
// Randomized + directed bench. The reference model is a queue of expected
// responses, each stamped with the cycle it must appear in (accept + LATENCY).
module tb_inst_fetch_responder;
    localparam int DEPTH = 4;
    localparam int LAT   = 5;

    logic        clk = 1'b0;
    logic        rst, req, cancel;
    logic [31:0] req_addr;
    logic [1:0]  req_ex;
    logic        addr_ok, data_ok, mem_en;
    logic [31:0] rdata, mem_addr, mem_rdata;
    logic [1:0]  resp_ex;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  ex;
    } exp_t;
    exp_t q[$];

    inst_fetch_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_ex(req_ex),
        .addr_ok(addr_ok), .cancel(cancel), .data_ok(data_ok), .rdata(rdata),
        .resp_ex(resp_ex), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram(input logic [31:0] a);
        if (a == 32'h1c000000) return 32'h02800c0c;
        return {a[15:0] ^ 16'hbeef, a[31:16] ^ a[15:0]};
    endfunction

    // Behavioural RAM: garbage when not enabled so forced-zero data is visible.
    always @(posedge clk) mem_rdata <= mem_en ? ram(mem_addr) : $urandom();

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, check handshake, update model.
    task automatic step(input logic r, input logic [31:0] a, input logic [1:0] e,
                        input logic c, input logic rs);
        logic exp_aok;
        @(posedge clk);
        #1;
        req = r; req_addr = a; req_ex = e; cancel = c; rst = rs;
        #1;
        exp_aok = !rs && !c && (q.size() < DEPTH);
        chk("addr_ok", addr_ok, exp_aok);
        chk("mem_en", mem_en, exp_aok && r && (e == 2'b00));
        if (rs || c) q.delete();
        else if (r && exp_aok) q.push_back('{cyc + LAT, (e != 2'b00) ? 32'h0 : ram(a), e});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    endtask

    // Monitor: response must appear exactly in its due cycle, in order.
    always @(negedge clk) begin
        logic exp_dok;
        exp_dok = !rst && !cancel && (q.size() > 0) && (q[0].due == cyc);
        chk("data_ok", data_ok, exp_dok);
        if (data_ok && exp_dok) begin
            chk("rdata", rdata, q[0].data);
            chk("resp_ex", 32'(resp_ex), 32'(q[0].ex));
            void'(q.pop_front());
        end else if (!data_ok) begin
            chk("rdata_idle", rdata, 32'h0);
            chk("resp_ex_idle", 32'(resp_ex), 32'h0);
        end
    end

    initial begin
        rst = 1'b1; req = 1'b0; cancel = 1'b0; req_addr = '0; req_ex = '0;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h1c000000, 2'b00, 1'b0, 1'b1);
        // single fetch with known RAM word
        step(1'b1, 32'h1c000000, 2'b00, 1'b0, 1'b0);
        idle(LAT + 2);
        // excepting fetch: no RAM read, zero data
        step(1'b1, 32'h1c000010, 2'b01, 1'b0, 1'b0);
        idle(LAT + 2);
        // request held high: fills, back-pressures, no same-cycle bypass
        for (int k = 0; k < 12; k++) step(1'b1, 32'h1c000100 + 32'(k * 4), 2'b00, 1'b0, 1'b0);
        idle(LAT + 2);
        // cancel drops the in-flight fetch; the next one returns normally
        step(1'b1, 32'h1c000000, 2'b00, 1'b0, 1'b0);
        step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
        step(1'b1, 32'h1c000040, 2'b00, 1'b0, 1'b0);
        idle(LAT + 2);
        // reset with fetches outstanding
        for (int k = 0; k < 3; k++) step(1'b1, 32'h1c000200 + 32'(k * 4), 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'h1c000300, 2'b00, 1'b0, 1'b1);
        step(1'b1, 32'h1c000304, 2'b00, 1'b0, 1'b0);
        idle(LAT + 2);
        // back-to-back sequential fetches
        for (int k = 0; k < 8; k++) step(1'b1, 32'h1c000000 + 32'(k * 4), 2'b00, 1'b0, 1'b0);
        idle(LAT + 2);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] e;
            e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step($urandom_range(0, 9) < 7,
                 32'h1c000000 + (32'($urandom_range(0, 1023)) << 2), e,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
        end
        idle(LAT + 3);
        chk("drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
